// File: rtl/qpsk_demod.sv
// Hard-decision QPSK demapper: integrate-and-dump over SPS samples, one {I,Q} bit pair per symbol.
// Latency: bit pair valid one cycle after the last sample of a symbol is accepted (show-ahead FIFO).
// Backpressure: 2-entry output FIFO; o_ready drops (registered) while it is full and samples stall.
// Optional: define QPSK_DEMOD_SOFT_EN to add per-symbol average soft outputs o_soft_I/o_soft_Q.

// Small generic synchronous FIFO with show-ahead head and registered not-full flag.
module qpsk_demod_fifo #(
    parameter int W     = 2,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_vld,
    input  logic [W-1:0] push_dat,
    output logic         push_rdy,
    output logic         pop_vld,
    output logic [W-1:0] pop_dat,
    input  logic         pop_rdy
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_d;
    logic          rdy_q;
    logic          do_push, do_pop;

    assign do_push  = push_vld && rdy_q;
    assign do_pop   = pop_rdy && (count != '0);
    assign push_rdy = rdy_q;
    assign pop_vld  = (count != '0);
    assign pop_dat  = pop_vld ? mem[rd_ptr] : '0;

    // Occupancy after this cycle's push/pop; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_d = count;
        case ({do_push, do_pop})
            2'b10:   count_d = count + CW'(1);
            2'b01:   count_d = count - CW'(1);
            default: count_d = count;
        endcase
    end

    // Storage, pointers, and the not-full flag registered from next occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rdy_q  <= 1'b0;
            for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            end
            if (do_pop) rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            count <= count_d;
            rdy_q <= (count_d < CW'(DEPTH));
        end
    end
endmodule

module qpsk_demod #(
    parameter int DATA_W = 12,
    parameter int SPS    = 4,
    parameter int ACC_W  = DATA_W + $clog2(SPS) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] i_I,
    input  logic [DATA_W-1:0] i_Q,
    input  logic              i_valid,
    input  logic              i_sync,
    output logic              o_ready,
    output logic              o_I,
    output logic              o_Q,
`ifdef QPSK_DEMOD_SOFT_EN
    output logic [DATA_W-1:0] o_soft_I,
    output logic [DATA_W-1:0] o_soft_Q,
`endif
    output logic              o_valid,
    input  logic              i_ready
);
    localparam int CNT_W = $clog2(SPS + 1);
    localparam int EXT_W = ACC_W - DATA_W;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SPS - 1);
`ifdef QPSK_DEMOD_SOFT_EN
    localparam int FW      = 2 + 2 * DATA_W;
    localparam int LOG_SPS = $clog2(SPS);
    localparam logic signed [ACC_W-1:0] SMAX = ACC_W'(2 ** (DATA_W - 1) - 1);
    localparam logic signed [ACC_W-1:0] SMIN = ACC_W'(-(2 ** (DATA_W - 1)));
`else
    localparam int FW = 2;
`endif

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t                   state_q, state_d;
    logic signed [ACC_W-1:0]  acc_i_q, acc_q_q, acc_i_d, acc_q_d;
    logic signed [ACC_W-1:0]  sum_i, sum_q;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     accept, load, push_vld;
    logic                     fifo_rdy, fifo_vld;
    logic [FW-1:0]            push_dat, head_dat;

    assign accept = i_valid && o_ready;
    // A sync-marked sample restarts the symbol exactly like the first sample from IDLE.
    assign load   = (state_q == IDLE) || i_sync;
    assign sum_i  = (load ? '0 : acc_i_q) + {{EXT_W{i_I[DATA_W-1]}}, i_I};
    assign sum_q  = (load ? '0 : acc_q_q) + {{EXT_W{i_Q[DATA_W-1]}}, i_Q};

`ifdef QPSK_DEMOD_SOFT_EN
    // Per-symbol average (floor) clamped to the sample range.
    function automatic logic [DATA_W-1:0] soft_avg(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] s;
        s = a >>> LOG_SPS;
        if (s > SMAX)      s = SMAX;
        else if (s < SMIN) s = SMIN;
        return s[DATA_W-1:0];
    endfunction
    assign push_dat = {sum_i[ACC_W-1], sum_q[ACC_W-1], soft_avg(sum_i), soft_avg(sum_q)};
`else
    assign push_dat = {sum_i[ACC_W-1], sum_q[ACC_W-1]};
`endif

    // Next-state: load/accumulate on each accepted sample, dump on the symbol's last sample.
    always_comb begin
        state_d  = state_q;
        acc_i_d  = acc_i_q;
        acc_q_d  = acc_q_q;
        cnt_d    = cnt_q;
        push_vld = 1'b0;
        if (accept) begin
            if (load ? (SPS == 1) : (cnt_q == LAST)) begin
                push_vld = 1'b1;
                acc_i_d  = '0;
                acc_q_d  = '0;
                cnt_d    = '0;
                state_d  = IDLE;
            end else begin
                acc_i_d  = sum_i;
                acc_q_d  = sum_q;
                cnt_d    = load ? CNT_W'(1) : cnt_q + CNT_W'(1);
                state_d  = ACCUM;
            end
        end
    end

    // State, accumulators and sample counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_i_q <= '0;
            acc_q_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_i_q <= acc_i_d;
            acc_q_q <= acc_q_d;
            cnt_q   <= cnt_d;
        end
    end

    qpsk_demod_fifo #(.W(FW), .DEPTH(2)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (push_vld),
        .push_dat (push_dat),
        .push_rdy (fifo_rdy),
        .pop_vld  (fifo_vld),
        .pop_dat  (head_dat),
        .pop_rdy  (i_ready)
    );

    // Outputs are forced quiet while reset is held, even before the first reset edge.
    assign o_ready = fifo_rdy && !rst;
    assign o_valid = fifo_vld && !rst;
    assign o_I     = rst ? 1'b0 : head_dat[FW-1];
    assign o_Q     = rst ? 1'b0 : head_dat[FW-2];
`ifdef QPSK_DEMOD_SOFT_EN
    assign o_soft_I = rst ? '0 : head_dat[2*DATA_W-1:DATA_W];
    assign o_soft_Q = rst ? '0 : head_dat[DATA_W-1:0];
`endif
endmodule
